spi_adc_responder: RTL and testbench

- Synthesizable SPI slave that stands in for the TLV2548-style ADC on the far end of the team's SPI master.
- Captures the 16-bit command the master shifts out on MOSI and presents it on a parallel port.
- Returns the most recently loaded 12-bit sample MSB-first on MISO in the same frame.
- Used as a loop-back target in FPGA self-test and as the bus partner in master-level simulation.

---
 rtl/spi_adc_responder.sv | 146 ++++++++++++++
 tb/tb_spi_adc_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// SPI slave standing in for a TLV2548-style ADC: captures a command word from MOSI
// and returns the latest loaded sample MSB-first on MISO within the same frame.
module spi_adc_responder #(
   parameter int P_CMD_WIDTH   = 16,
   parameter int P_DATA_WIDTH  = 12,
   parameter int P_SYNC_STAGES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_spi_cs,
   input  logic                    i_spi_sck,
   input  logic                    i_spi_mosi,
   output logic                    o_spi_miso,
   output logic                    o_miso_oe,
   input  logic [P_DATA_WIDTH-1:0] i_sample_data,
   input  logic                    i_sample_valid,
   output logic [P_CMD_WIDTH-1:0]  o_cmd_data,
   output logic                    o_cmd_valid,
   output logic                    o_frame_err,
   output logic                    o_busy
);

   localparam int                  LP_CNT_W = $clog2(P_CMD_WIDTH);
   localparam logic [LP_CNT_W-1:0] LP_LAST  = LP_CNT_W'(P_CMD_WIDTH - 1);
   localparam int                  LP_PAD   = P_CMD_WIDTH - P_DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                   state, state_nxt;
   logic [P_SYNC_STAGES-1:0] cs_chain, sck_chain, mosi_chain;
   logic                     cs_s, sck_s, mosi_s, cs_d, sck_d;
   logic                     cs_fall, cs_rise, sck_rise, sck_fall;
   logic                     start, abort, rx_shift, tx_shift, cmd_done, err;
   logic [P_DATA_WIDTH-1:0]  sample_reg;
   logic [P_CMD_WIDTH-1:0]   tx_reg, rx_reg;
   logic [LP_CNT_W-1:0]      bit_cnt;

   // CS idles high, so its chain resets to 1 and a frame needs a genuine CS fall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cs_chain   <= '1;
         sck_chain  <= '0;
         mosi_chain <= '0;
         cs_d       <= 1'b1;
         sck_d      <= 1'b0;
      end else begin
         cs_chain   <= {cs_chain[P_SYNC_STAGES-2:0], i_spi_cs};
         sck_chain  <= {sck_chain[P_SYNC_STAGES-2:0], i_spi_sck};
         mosi_chain <= {mosi_chain[P_SYNC_STAGES-2:0], i_spi_mosi};
         cs_d       <= cs_s;
         sck_d      <= sck_s;
      end
   end

   assign cs_s     = cs_chain[P_SYNC_STAGES-1];
   assign sck_s    = sck_chain[P_SYNC_STAGES-1];
   assign mosi_s   = mosi_chain[P_SYNC_STAGES-1];
   assign cs_fall  = cs_d & ~cs_s;
   assign cs_rise  = ~cs_d & cs_s;
   assign sck_rise = ~sck_d & sck_s;
   assign sck_fall = sck_d & ~sck_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // A CS rise overrides any SCK edge seen in the same cycle.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      abort     = 1'b0;
      rx_shift  = 1'b0;
      tx_shift  = 1'b0;
      cmd_done  = 1'b0;
      err       = 1'b0;
      if (cs_rise) begin
         state_nxt = IDLE;
         abort     = 1'b1;
         err       = (state == SHIFT);
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state_nxt = SHIFT;
                  start     = 1'b1;
               end
            end
            SHIFT: begin
               if (sck_rise) begin
                  rx_shift = 1'b1;
                  if (bit_cnt == LP_LAST) begin
                     cmd_done  = 1'b1;
                     state_nxt = HOLD;
                  end
               end
               tx_shift = sck_fall;
            end
            HOLD:    tx_shift = sck_fall;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sample_reg  <= '0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         bit_cnt     <= '0;
         o_spi_miso  <= 1'b0;
         o_miso_oe   <= 1'b0;
         o_busy      <= 1'b0;
         o_cmd_data  <= '0;
         o_cmd_valid <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_cmd_valid <= cmd_done;
         o_frame_err <= err;
         if (i_sample_valid) sample_reg <= i_sample_data;
         if (start) begin
            tx_reg     <= P_CMD_WIDTH'(sample_reg) << LP_PAD;
            o_spi_miso <= sample_reg[P_DATA_WIDTH-1];
            bit_cnt    <= '0;
            o_miso_oe  <= 1'b1;
            o_busy     <= 1'b1;
         end
         if (abort) begin
            o_spi_miso <= 1'b0;
            o_miso_oe  <= 1'b0;
            o_busy     <= 1'b0;
         end
         // Zeros fill in behind the sample so MISO reads 0 once the data is exhausted.
         if (tx_shift) begin
            tx_reg     <= {tx_reg[P_CMD_WIDTH-2:0], 1'b0};
            o_spi_miso <= tx_reg[P_CMD_WIDTH-2];
         end
         if (rx_shift) begin
            rx_reg  <= {rx_reg[P_CMD_WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + LP_CNT_W'(1);
         end
         if (cmd_done) o_cmd_data <= {rx_reg[P_CMD_WIDTH-2:0], mosi_s};
      end
   end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: an SPI master task drives frames, a reference model
// queues expected command/error events and a monitor checks them as they appear.
module tb_spi_adc_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_cs = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, miso_oe;
   logic [11:0] sample_data = '0;
   logic        sample_valid = 1'b0;
   logic [15:0] cmd_data;
   logic        cmd_valid, frame_err, busy;

   typedef struct {
      bit          is_err;
      logic [15:0] cmd;
   } ev_t;

   ev_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [11:0] m_sample = '0;   // model of the sample register
   logic [15:0] mon_last = '0;   // model of o_cmd_data

   always #5 clk = ~clk;

   spi_adc_responder dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_spi_cs       (spi_cs),
      .i_spi_sck      (spi_sck),
      .i_spi_mosi     (spi_mosi),
      .o_spi_miso     (spi_miso),
      .o_miso_oe      (miso_oe),
      .i_sample_data  (sample_data),
      .i_sample_valid (sample_valid),
      .o_cmd_data     (cmd_data),
      .o_cmd_valid    (cmd_valid),
      .o_frame_err    (frame_err),
      .o_busy         (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_sample(input logic [11:0] v);
      sample_data  = v;
      sample_valid = 1'b1;
      wait_clk(1);
      sample_valid = 1'b0;
      m_sample     = v;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},  32'(spi_miso),  0);
      check({tag, "_oe"},    32'(miso_oe),   0);
      check({tag, "_cmd"},   32'(cmd_data),  0);
      check({tag, "_valid"}, 32'(cmd_valid), 0);
      check({tag, "_err"},   32'(frame_err), 0);
      check({tag, "_busy"},  32'(busy),      0);
   endtask

   // One master frame: nrise SCK pulses at 5 clk per phase, MISO sampled just before each rise.
   task automatic frame(input logic [15:0] cmd, input int nrise, input int load_at,
                        input logic [11:0] load_val, input int rst_at, input int gap);
      logic [11:0] snap;
      logic        exp_bit;
      ev_t         ev;
      snap = m_sample;
      if (rst_at < 0) begin
         ev.is_err = (nrise < 16);
         ev.cmd    = cmd;
         exp_q.push_back(ev);
      end
      spi_cs = 1'b0;
      wait_clk(6);
      check("busy_in_frame", 32'(busy), 1);
      check("oe_in_frame", 32'(miso_oe), 1);
      for (int k = 0; k < nrise; k++) begin
         spi_mosi = (k < 16) ? cmd[15-k] : 1'($urandom_range(0, 1));
         wait_clk(5);
         exp_bit = (k < 12) ? snap[11-k] : 1'b0;
         check($sformatf("miso_bit%0d", k), 32'(spi_miso), 32'(exp_bit));
         spi_sck = 1'b1;
         if (k == load_at) begin
            load_sample(load_val);
            wait_clk(4);
         end else begin
            wait_clk(5);
         end
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("rst_mid");
            m_sample = '0;
            mon_last = '0;
            spi_cs   = 1'b1;
            spi_sck  = 1'b0;
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(gap);
            return;
         end
         spi_sck = 1'b0;
      end
      wait_clk(5);
      spi_cs = 1'b1;
      wait_clk(3);
      check("busy_after_cs", 32'(busy), 0);
      check("oe_after_cs", 32'(miso_oe), 0);
      check("miso_after_cs", 32'(spi_miso), 0);
      wait_clk(gap - 3);
   endtask

   // Monitor: every cmd_valid / frame_err pulse must match the next queued expectation.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (rst_n && (cmd_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event valid=%0b err=%0b required none", cmd_valid, frame_err);
            end else begin
               ev = exp_q.pop_front();
               if (ev.is_err) begin
                  check("frame_err", 32'(frame_err), 1);
                  check("no_valid_on_err", 32'(cmd_valid), 0);
                  check("cmd_held", 32'(cmd_data), 32'(mon_last));
               end else begin
                  check("cmd_valid", 32'(cmd_valid), 1);
                  check("no_err_on_cmd", 32'(frame_err), 0);
                  check("cmd_data", 32'(cmd_data), 32'(ev.cmd));
                  mon_last = ev.cmd;
               end
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_clk(3);
      check_reset_outputs("rst_init");
      rst_n = 1'b1;
      wait_clk(3);
      check_reset_outputs("post_rst");

      // Directed cases
      load_sample(12'hA5C);
      wait_clk(2);
      frame(16'h3C81, 16, -1, '0, -1, 8);
      load_sample(12'hFFF);
      frame(16'hBEEF, 30, -1, '0, -1, 8);
      frame(16'h1234, 9, -1, '0, -1, 8);
      frame(16'h5AA5, 16, -1, '0, -1, 8);
      load_sample(12'h456);
      frame(16'hC001, 16, 5, 12'h123, -1, 8);
      frame(16'h7E7E, 16, -1, '0, -1, 8);
      frame(16'hFFFF, 16, -1, '0, 7, 8);
      check_reset_outputs("after_rst_frame");
      frame(16'h0001, 16, -1, '0, -1, 4);
      frame(16'h8000, 16, -1, '0, -1, 4);
      frame(16'h4321, 20, -1, '0, -1, 8);

      // Randomized frames
      for (int i = 0; i < 15; i++) begin
         logic [15:0] c;
         int          n;
         int          ld;
         c  = 16'($urandom);
         n  = $urandom_range(1, 30);
         ld = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         if ($urandom_range(0, 1) == 1) load_sample(12'($urandom));
         frame(c, n, ld, 12'($urandom), -1, $urandom_range(4, 10));
      end

      wait_clk(20);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
